// File: rtl/naval_attack_engine_if.sv
// Purpose: bundles the naval attack engine's control inputs and display/status outputs.
// Latency: none, this is wiring only.
// Backpressure: none; every signal is a plain level and there is no stall path.
interface naval_attack_if #(
   parameter int ROWS = 7,
   parameter int COLS = 5
);
   localparam int N  = ROWS * COLS;
   localparam int XW = $clog2(COLS);
   localparam int YW = $clog2(ROWS);
   localparam int CW = $clog2(N + 1);

   // Player side: switches and buttons.
   logic [N-1:0]  map_in;
   logic          load_map;
   logic          start;
   logic [XW-1:0] x_coord;
   logic [YW-1:0] y_coord;
   logic          confirmAttack;

   // Display side: matrix image, status values and shot-result flags.
   logic [1:0]    state;
   logic [N-1:0]  matriz_data;
   logic [N-1:0]  hit_mask;
   logic [N-1:0]  miss_mask;
   logic [7:0]    shots_left;
   logic [CW-1:0] hits_count;
   logic          hit_pulse;
   logic          miss_pulse;
   logic          repeat_pulse;
   logic          invalid_pulse;
   logic          game_won;
   logic          game_lost;

   modport master (
      output map_in, load_map, start, x_coord, y_coord, confirmAttack,
      input  state, matriz_data, hit_mask, miss_mask, shots_left, hits_count,
      input  hit_pulse, miss_pulse, repeat_pulse, invalid_pulse, game_won, game_lost
   );

   modport slave (
      input  map_in, load_map, start, x_coord, y_coord, confirmAttack,
      output state, matriz_data, hit_mask, miss_mask, shots_left, hits_count,
      output hit_pulse, miss_pulse, repeat_pulse, invalid_pulse, game_won, game_lost
   );
endinterface

// File: rtl/naval_attack_engine.sv
// Purpose: naval-battle game engine holding the ship map, shot history, shot budget and game FSM.
// Latency: a shot fired on a clk edge shows its result (masks, counters, pulses) in the next cycle.
// Backpressure: none; one shot per confirm rising edge, and edges outside ATTACK are dropped.
module naval_attack_engine #(
   parameter int ROWS      = 7,
   parameter int COLS      = 5,
   parameter int MAX_SHOTS = 10
) (
   input  logic          clk,
   input  logic          reset,
   naval_attack_if.slave bus
);
   localparam int N  = ROWS * COLS;
   localparam int CW = $clog2(N + 1);

   typedef enum logic [1:0] {
      IDLE   = 2'b00,
      PREP   = 2'b01,
      ATTACK = 2'b10,
      OVER   = 2'b11
   } state_t;

   state_t        state_q, state_d;
   logic [N-1:0]  map_q, map_d;
   logic [N-1:0]  hit_q, hit_d;
   logic [N-1:0]  miss_q, miss_d;
   logic [7:0]    shots_q, shots_d;
   logic [CW-1:0] hits_q, hits_d;
   logic [3:0]    pulse_q, pulse_d;   // {hit, miss, repeat, invalid}
   logic          won_q, won_d;
   logic          lost_q, lost_d;
   logic          conf_q;
   logic [CW-1:0] ship_cnt;
   logic          fire;
   logic          in_range;
   logic          shot_taken;
   logic          ship_here;
   logic [N-1:0]  shot_bit;

   // Count the ship cells of the stored map; reaching this many hits wins the game.
   always_comb begin
      ship_cnt = '0;
      for (int i = 0; i < N; i++) begin
         ship_cnt = ship_cnt + CW'(map_q[i]);
      end
   end

   // Decode the shot: rising confirm edge in ATTACK, target cell as a one-hot vector.
   // An out-of-range target is filtered by in_range before shot_bit is ever used.
   always_comb begin
      fire       = bus.confirmAttack & ~conf_q & (state_q == ATTACK);
      in_range   = (32'(bus.x_coord) < 32'(COLS)) && (32'(bus.y_coord) < 32'(ROWS));
      shot_bit   = N'(1) << (32'(bus.y_coord) * 32'(COLS) + 32'(bus.x_coord));
      shot_taken = |((hit_q | miss_q) & shot_bit);
      ship_here  = |(map_q & shot_bit);
   end

   // Next game state and datapath values.
   always_comb begin
      state_d = state_q;
      map_d   = map_q;
      hit_d   = hit_q;
      miss_d  = miss_q;
      shots_d = shots_q;
      hits_d  = hits_q;
      won_d   = won_q;
      lost_d  = lost_q;
      pulse_d = 4'b0000;
      case (state_q)
         IDLE: begin
            if (bus.load_map) begin
               map_d   = bus.map_in;
               state_d = PREP;
            end
         end
         PREP: begin
            // A load on the same cycle as start wins; an empty map cannot be played.
            if (bus.load_map) begin
               map_d = bus.map_in;
            end else if (bus.start && (|map_q)) begin
               state_d = ATTACK;
            end
         end
         ATTACK: begin
            if (fire) begin
               if (!in_range) begin
                  pulse_d = 4'b0001;
               end else if (shot_taken) begin
                  pulse_d = 4'b0010;
               end else begin
                  shots_d = shots_q - 8'd1;
                  if (ship_here) begin
                     hit_d   = hit_q | shot_bit;
                     hits_d  = hits_q + CW'(1);
                     pulse_d = 4'b1000;
                  end else begin
                     miss_d  = miss_q | shot_bit;
                     pulse_d = 4'b0100;
                  end
                  // Sinking the last ship on the last shot is a win.
                  if (ship_here && ((hits_q + CW'(1)) == ship_cnt)) begin
                     state_d = OVER;
                     won_d   = 1'b1;
                  end else if (shots_q == 8'd1) begin
                     state_d = OVER;
                     lost_d  = 1'b1;
                  end
               end
            end
         end
         OVER: begin
            // New round on the same map.
            if (bus.start) begin
               state_d = PREP;
               hit_d   = '0;
               miss_d  = '0;
               shots_d = 8'(MAX_SHOTS);
               hits_d  = '0;
               won_d   = 1'b0;
               lost_d  = 1'b0;
            end
         end
         default: state_d = IDLE;
      endcase
   end

   // Game registers; reset discards the map as well as all progress.
   always_ff @(posedge clk) begin
      if (reset) begin
         state_q <= IDLE;
         map_q   <= '0;
         hit_q   <= '0;
         miss_q  <= '0;
         shots_q <= 8'(MAX_SHOTS);
         hits_q  <= '0;
         pulse_q <= 4'b0000;
         won_q   <= 1'b0;
         lost_q  <= 1'b0;
         conf_q  <= 1'b0;
      end else begin
         state_q <= state_d;
         map_q   <= map_d;
         hit_q   <= hit_d;
         miss_q  <= miss_d;
         shots_q <= shots_d;
         hits_q  <= hits_d;
         pulse_q <= pulse_d;
         won_q   <= won_d;
         lost_q  <= lost_d;
         conf_q  <= bus.confirmAttack;
      end
   end

   // Matrix image: the map while setting up or reviewing, only the hits while attacking.
   always_comb begin
      case (state_q)
         PREP, OVER: bus.matriz_data = map_q;
         ATTACK:     bus.matriz_data = hit_q;
         default:    bus.matriz_data = '0;
      endcase
   end

   assign bus.state         = state_q;
   assign bus.hit_mask      = hit_q;
   assign bus.miss_mask     = miss_q;
   assign bus.shots_left    = shots_q;
   assign bus.hits_count    = hits_q;
   assign bus.hit_pulse     = pulse_q[3];
   assign bus.miss_pulse    = pulse_q[2];
   assign bus.repeat_pulse  = pulse_q[1];
   assign bus.invalid_pulse = pulse_q[0];
   assign bus.game_won      = won_q;
   assign bus.game_lost     = lost_q;
endmodule

// File: tb/tb_naval_attack_engine.sv
// Purpose: self-checking bench for naval_attack_engine in a 7x5/10-shot and a 4x4/1-shot build.
// Latency: results are sampled 1 time unit after the clk edge that evaluates a shot.
// Backpressure: none; the bench drives one input vector per cycle.
module tb_naval_attack_engine;
   logic clk = 1'b0;
   logic reset;

   always #5 clk = ~clk;

   naval_attack_if #(.ROWS(7), .COLS(5)) ifa ();
   naval_attack_if #(.ROWS(4), .COLS(4)) ifb ();

   naval_attack_engine #(.ROWS(7), .COLS(5), .MAX_SHOTS(10)) dut_a (
      .clk(clk), .reset(reset), .bus(ifa)
   );
   naval_attack_engine #(.ROWS(4), .COLS(4), .MAX_SHOTS(1)) dut_b (
      .clk(clk), .reset(reset), .bus(ifb)
   );

   int n_checks = 0;
   int n_pass   = 0;
   int sel      = 0;    // 0: 7x5 build, 1: 4x4 build

   // Reference game: per-cell shot record plus plain counters.
   int          m_rows, m_cols, m_max;
   int          m_state;
   logic [63:0] m_map;
   int          m_cell [64];   // 0 untouched, 1 hit, 2 miss
   int          m_shots, m_hits;
   bit          m_won, m_lost, m_conf;
   logic [3:0]  m_pulse;

   logic [63:0] o_st, o_mat, o_hm, o_mm, o_sh, o_hc, o_pl, o_won, o_lost;

   task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
      n_checks++;
      if (got === exp) n_pass++;
      else $display("FAIL %s: got %0h expected %0h", tag, got, exp);
   endtask

   function automatic logic [63:0] cell_mask();
      return (64'd1 << (m_rows * m_cols)) - 64'd1;
   endfunction

   function automatic int ships();
      int c = 0;
      for (int i = 0; i < m_rows * m_cols; i++) if (m_map[i]) c++;
      return c;
   endfunction

   function automatic logic [63:0] mask_of(input int kind);
      logic [63:0] m = '0;
      for (int i = 0; i < m_rows * m_cols; i++) if (m_cell[i] == kind) m[i] = 1'b1;
      return m;
   endfunction

   task automatic model_reset();
      m_state = 0; m_map = '0; m_shots = m_max; m_hits = 0;
      m_won = 0; m_lost = 0; m_conf = 0; m_pulse = 4'b0000;
      for (int i = 0; i < 64; i++) m_cell[i] = 0;
   endtask

   task automatic model_cycle(input bit rst, input bit ld, input bit st, input int x, input int y,
                              input bit cf, input logic [63:0] mp);
      bit fire;
      int idx;
      if (rst) begin
         model_reset();
         return;
      end
      fire    = cf && !m_conf && (m_state == 2);
      m_conf  = cf;
      m_pulse = 4'b0000;
      case (m_state)
         0: if (ld) begin m_map = mp; m_state = 1; end
         1: begin
            if (ld) m_map = mp;
            else if (st && m_map != 0) m_state = 2;
         end
         2: if (fire) begin
            if (x >= m_cols || y >= m_rows) m_pulse = 4'b0001;
            else begin
               idx = y * m_cols + x;
               if (m_cell[idx] != 0) m_pulse = 4'b0010;
               else begin
                  m_shots--;
                  if (m_map[idx]) begin m_cell[idx] = 1; m_hits++; m_pulse = 4'b1000; end
                  else begin m_cell[idx] = 2; m_pulse = 4'b0100; end
                  if (m_map[idx] && m_hits == ships()) begin m_state = 3; m_won = 1; end
                  else if (m_shots == 0) begin m_state = 3; m_lost = 1; end
               end
            end
         end
         3: if (st) begin
            for (int i = 0; i < 64; i++) m_cell[i] = 0;
            m_shots = m_max; m_hits = 0; m_won = 0; m_lost = 0; m_state = 1;
         end
         default: ;
      endcase
   endtask

   task automatic sample();
      if (sel == 0) begin
         o_st = 64'(ifa.state);      o_mat = 64'(ifa.matriz_data);
         o_hm = 64'(ifa.hit_mask);   o_mm  = 64'(ifa.miss_mask);
         o_sh = 64'(ifa.shots_left); o_hc  = 64'(ifa.hits_count);
         o_pl = 64'({ifa.hit_pulse, ifa.miss_pulse, ifa.repeat_pulse, ifa.invalid_pulse});
         o_won = 64'(ifa.game_won);  o_lost = 64'(ifa.game_lost);
      end else begin
         o_st = 64'(ifb.state);      o_mat = 64'(ifb.matriz_data);
         o_hm = 64'(ifb.hit_mask);   o_mm  = 64'(ifb.miss_mask);
         o_sh = 64'(ifb.shots_left); o_hc  = 64'(ifb.hits_count);
         o_pl = 64'({ifb.hit_pulse, ifb.miss_pulse, ifb.repeat_pulse, ifb.invalid_pulse});
         o_won = 64'(ifb.game_won);  o_lost = 64'(ifb.game_lost);
      end
   endtask

   task automatic check_model();
      logic [63:0] exp_mat;
      sample();
      case (m_state)
         1, 3:    exp_mat = m_map;
         2:       exp_mat = mask_of(1);
         default: exp_mat = '0;
      endcase
      chk("state", o_st, 64'(m_state));
      chk("matriz_data", o_mat, exp_mat);
      chk("hit_mask", o_hm, mask_of(1));
      chk("miss_mask", o_mm, mask_of(2));
      chk("shots_left", o_sh, 64'(m_shots));
      chk("hits_count", o_hc, 64'(m_hits));
      chk("pulses", o_pl, 64'(m_pulse));
      chk("game_won", o_won, 64'(m_won));
      chk("game_lost", o_lost, 64'(m_lost));
   endtask

   task automatic cyc(input bit rst, input bit ld, input bit st, input int x, input int y,
                      input bit cf, input logic [63:0] mp);
      @(negedge clk);
      reset = rst;
      if (sel == 0) begin
         ifa.load_map = ld; ifa.start = st; ifa.confirmAttack = cf;
         ifa.x_coord = 3'(x); ifa.y_coord = 3'(y); ifa.map_in = mp[34:0];
      end else begin
         ifb.load_map = ld; ifb.start = st; ifb.confirmAttack = cf;
         ifb.x_coord = 2'(x); ifb.y_coord = 2'(y); ifb.map_in = mp[15:0];
      end
      @(posedge clk);
      model_cycle(rst, ld, st, x, y, cf, mp & cell_mask());
      #1;
      check_model();
   endtask

   task automatic idle();
      cyc(0, 0, 0, 0, 0, 0, '0);
   endtask

   task automatic shoot(input int x, input int y);
      cyc(0, 0, 0, x, y, 1, '0);
      cyc(0, 0, 0, x, y, 0, '0);
   endtask

   task automatic random_games(input int games, input int xmax, input int ymax);
      logic [63:0] mp;
      for (int g = 0; g < games; g++) begin
         cyc(1, 0, 0, 0, 0, 0, '0);
         mp = {$urandom, $urandom} & {$urandom, $urandom} & cell_mask();
         if (mp == 0) mp[$urandom_range(0, m_rows * m_cols - 1)] = 1'b1;
         cyc(0, 1, 0, 0, 0, 0, mp);
         cyc(0, 0, 1, 0, 0, 0, '0);
         for (int c = 0; c < 45; c++) begin
            cyc($urandom_range(0, 199) == 0, $urandom_range(0, 15) == 0,
                $urandom_range(0, 15) == 0, $urandom_range(0, xmax), $urandom_range(0, ymax),
                $urandom_range(0, 1) == 1, {$urandom, $urandom});
         end
      end
   endtask

   initial begin
      reset = 1'b1;
      ifa.load_map = 0; ifa.start = 0; ifa.confirmAttack = 0; ifa.x_coord = '0; ifa.y_coord = '0; ifa.map_in = '0;
      ifb.load_map = 0; ifb.start = 0; ifb.confirmAttack = 0; ifb.x_coord = '0; ifb.y_coord = '0; ifb.map_in = '0;

      // 7x5 build, 10 shots.
      sel = 0; m_rows = 7; m_cols = 5; m_max = 10; model_reset();
      cyc(1, 0, 0, 0, 0, 0, '0);
      cyc(1, 0, 0, 0, 0, 0, '0);
      chk("reset_state", o_st, 64'd0);
      chk("reset_shots", o_sh, 64'd10);
      cyc(0, 1, 0, 0, 0, 0, 64'h1F);
      chk("load_state", o_st, 64'd1);
      chk("prep_matriz", o_mat, 64'h1F);
      cyc(0, 0, 1, 0, 0, 0, '0);
      cyc(0, 0, 1, 0, 0, 0, '0);
      chk("attack_state", o_st, 64'd2);
      chk("attack_shots", o_sh, 64'd10);
      chk("attack_matriz", o_mat, 64'd0);
      cyc(0, 0, 0, 2, 0, 1, '0);
      chk("hit_pulse", o_pl, 64'b1000);
      chk("hit_mask_first", o_hm, 64'h4);
      chk("hits_first", o_hc, 64'd1);
      chk("shots_first", o_sh, 64'd9);
      for (int i = 0; i < 4; i++) cyc(0, 0, 0, 2, 0, 1, '0);
      chk("held_no_refire", o_sh, 64'd9);
      chk("held_pulse_low", o_pl, 64'd0);
      idle();
      cyc(0, 0, 0, 2, 0, 1, '0);
      chk("repeat_pulse", o_pl, 64'b0010);
      idle();
      cyc(0, 0, 0, 5, 0, 1, '0);
      chk("invalid_pulse", o_pl, 64'b0001);
      chk("invalid_shots", o_sh, 64'd9);
      chk("invalid_hit_mask", o_hm, 64'h4);
      idle();
      shoot(0, 0); shoot(1, 0); shoot(3, 0); shoot(4, 0);
      chk("win_state", o_st, 64'd3);
      chk("win_flag", o_won, 64'd1);
      chk("win_shots", o_sh, 64'd5);
      cyc(0, 0, 1, 0, 0, 0, '0);
      chk("replay_state", o_st, 64'd1);
      chk("replay_hit_mask", o_hm, 64'd0);
      chk("replay_shots", o_sh, 64'd10);
      chk("replay_map", o_mat, 64'h1F);
      cyc(0, 0, 1, 0, 0, 0, '0);
      for (int x = 0; x < 5; x++) shoot(x, 3);
      shoot(0, 3);
      for (int x = 0; x < 5; x++) shoot(x, 4);
      chk("lose_state", o_st, 64'd3);
      chk("lose_flag", o_lost, 64'd1);
      chk("lose_won_low", o_won, 64'd0);
      chk("lose_miss_mask", o_mm, 64'h1FF8000);
      shoot(1, 1); shoot(2, 2);
      chk("over_ignores_fire", o_mm, 64'h1FF8000);
      random_games(40, 7, 7);

      // 4x4 build, single shot.
      sel = 1; m_rows = 4; m_cols = 4; m_max = 1; model_reset();
      cyc(1, 0, 0, 0, 0, 0, '0);
      cyc(0, 1, 0, 0, 0, 0, '0);
      cyc(0, 0, 1, 0, 0, 0, '0);
      chk("zero_map_start", o_st, 64'd1);
      cyc(0, 1, 1, 0, 0, 0, 64'h8000);
      chk("load_beats_start", o_st, 64'd1);
      cyc(0, 0, 1, 0, 0, 0, '0);
      chk("b_attack", o_st, 64'd2);
      cyc(0, 0, 0, 3, 3, 1, '0);
      chk("b_last_shot_won", o_won, 64'd1);
      chk("b_last_shot_lost", o_lost, 64'd0);
      chk("b_shots_zero", o_sh, 64'd0);
      cyc(0, 0, 1, 0, 0, 0, '0);
      cyc(0, 0, 1, 0, 0, 0, '0);
      chk("b_reattack", o_st, 64'd2);
      cyc(1, 0, 0, 0, 0, 0, '0);
      chk("b_reset_state", o_st, 64'd0);
      chk("b_reset_matriz", o_mat, 64'd0);
      chk("b_reset_shots", o_sh, 64'd1);
      chk("b_reset_pulses", o_pl, 64'd0);
      random_games(40, 3, 3);

      $display("%0d/%0d checks passed", n_pass, n_checks);
      $finish;
   end
endmodule
